// File: rtl/snake_dir_ctrl.sv
// Raw push-buttons -> synchronised, debounced, edge-detected snake direction code.
// Define SNAKE_DIR_PAUSE_EN to add a btn_pause input that toggles moveState to/from code 4.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int INIT_DIR        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
`ifdef SNAKE_DIR_PAUSE_EN
    input  logic       btn_pause,
`endif
    output logic [3:0] moveState,
    output logic       dir_changed,
`ifdef SNAKE_DIR_PAUSE_EN
    output logic [4:0] btn_deb
`else
    output logic [3:0] btn_deb
`endif
);

    localparam int NB = $bits(btn_deb);

    logic [NB-1:0]    btn_raw;
    logic [NB-1:0]    sync1_q, sync1_d;
    logic [NB-1:0]    sync2_q, sync2_d;
    logic [NB-1:0]    deb_q, deb_d;
    logic [NB-1:0]    deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [3:0]       move_state_q, move_state_d;
    logic             dir_changed_q, dir_changed_d;
    logic [NB-1:0]    rise;
    logic [1:0]       ref_dir;
    logic [1:0]       win;
    logic             take;

`ifdef SNAKE_DIR_PAUSE_EN
    logic [1:0] last_dir_q, last_dir_d;
    assign btn_raw = {btn_pause, btn_right, btn_left, btn_down, btn_up};
    assign ref_dir = last_dir_q;
`else
    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};
    assign ref_dir = move_state_q[1:0];
`endif

    // A rise is usable only when it turns onto the other axis (not same, not reverse).
    function automatic logic dir_valid(input logic [1:0] code, input logic [1:0] cur);
        return (code != cur) && (code != (cur ^ 2'b01));
    endfunction

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        sync1_d    = btn_raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        take          = 1'b0;
        win           = 2'd0;
        move_state_d  = move_state_q;
        dir_changed_d = 1'b0;
        // Scan lowest priority first so up (bit 0) overwrites everything else.
        for (int i = 3; i >= 0; i--) begin
            if (rise[i] && dir_valid(2'(i), ref_dir)) begin
                take = 1'b1;
                win  = 2'(i);
            end
        end
`ifdef SNAKE_DIR_PAUSE_EN
        last_dir_d = last_dir_q;
        if (rise[4]) begin
            dir_changed_d = 1'b1;
            // last_dir_q already tracks the running direction, so pausing leaves it alone.
            move_state_d  = move_state_q[2] ? {2'b00, last_dir_q} : 4'd4;
        end else if (take) begin
            dir_changed_d = 1'b1;
            move_state_d  = {2'b00, win};
            last_dir_d    = win;
        end
`else
        if (take) begin
            dir_changed_d = 1'b1;
            move_state_d  = {2'b00, win};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_prev_q    <= '0;
            move_state_q  <= 4'(INIT_DIR);
            dir_changed_q <= 1'b0;
            // NOTE: the counter array is plain flops and must restart from zero, so it is reset like any register.
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
`ifdef SNAKE_DIR_PAUSE_EN
            last_dir_q    <= 2'(INIT_DIR);
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_prev_q    <= deb_prev_d;
            move_state_q  <= move_state_d;
            dir_changed_q <= dir_changed_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
`ifdef SNAKE_DIR_PAUSE_EN
            last_dir_q    <= last_dir_d;
`endif
        end
    end

    assign moveState   = move_state_q;
    assign dir_changed = dir_changed_q;
    assign btn_deb     = deb_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4, INIT_DIR=3.
// Optional pause scenario runs only when SNAKE_DIR_PAUSE_EN is defined.
module tb_snake_dir_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [3:0] moveState;
    logic       dir_changed;
`ifdef SNAKE_DIR_PAUSE_EN
    logic       btn_pause;
    logic [4:0] btn_deb;
`else
    logic [3:0] btn_deb;
`endif

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int up_seen = 0;

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20),
        .INIT_DIR       (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_up     (btn[0]),
        .btn_down   (btn[1]),
        .btn_left   (btn[2]),
        .btn_right  (btn[3]),
`ifdef SNAKE_DIR_PAUSE_EN
        .btn_pause  (btn_pause),
`endif
        .moveState  (moveState),
        .dir_changed(dir_changed),
        .btn_deb    (btn_deb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (dir_changed === 1'b1) pulses++;
            if (btn_deb[0] === 1'b1) up_seen++;
        end
    endtask

    // Press a button pattern, expect a new code after 7 edges, then release and let it settle.
    task automatic steer(input string tag, input logic [3:0] mask, input logic [3:0] exp);
        btn = mask;
        tick(7);
        check(tag, moveState, exp);
        btn = 4'b0000;
        tick(8);
    endtask

    initial begin
        reset = 1'b1;
        btn   = 4'b0000;
`ifdef SNAKE_DIR_PAUSE_EN
        btn_pause = 1'b0;
`endif
        tick(3);
        check("rst_hold_ms", moveState, 4'd3);
        reset = 1'b0;
        tick(1);
        check("rst_ms", moveState, 4'd3);
        check("rst_dc", dir_changed, 1'b0);
        check("rst_deb", btn_deb, 0);

        // Latency: up rises at edge 7 only, pulse lasts one cycle, holding repeats nothing.
        pulses = 0;
        btn = 4'b0001;
        tick(6);
        check("lat_e6_ms", moveState, 4'd3);
        check("lat_e6_dc", dir_changed, 1'b0);
        tick(1);
        check("lat_e7_ms", moveState, 4'd0);
        check("lat_e7_dc", dir_changed, 1'b1);
        check("lat_e7_deb", btn_deb, 1);
        tick(1);
        check("lat_e8_dc", dir_changed, 1'b0);
        tick(10);
        check("hold_ms", moveState, 4'd0);
        check("hold_pulses", pulses, 1);
        btn = 4'b0000;
        tick(8);
        check("release_deb", btn_deb, 0);
        check("release_ms", moveState, 4'd0);

        // Reverse rejection, then a valid turn.
        steer("to_right", 4'b1000, 4'd3);
        pulses = 0;
        btn = 4'b0100;
        tick(12);
        check("rev_ms", moveState, 4'd3);
        check("rev_pulses", pulses, 0);
        btn = 4'b0000;
        tick(8);
        steer("to_down", 4'b0010, 4'd1);
        steer("to_left", 4'b0100, 4'd2);

        // Bouncing up (2 high / 2 low) never reaches the debounced level.
        pulses  = 0;
        up_seen = 0;
        repeat (10) begin
            btn = 4'b0001;
            tick(2);
            btn = 4'b0000;
            tick(2);
        end
        tick(8);
        check("bounce_deb", up_seen, 0);
        check("bounce_pulses", pulses, 0);
        check("bounce_ms", moveState, 4'd2);

        // Simultaneous up+down from left: up wins with a single pulse.
        pulses = 0;
        btn = 4'b0011;
        tick(7);
        check("prio_ms", moveState, 4'd0);
        tick(5);
        check("prio_pulses", pulses, 1);
        btn = 4'b0000;
        tick(8);
        steer("to_left2", 4'b0100, 4'd2);
        steer("to_down2", 4'b0010, 4'd1);

        // Same cycle up+down while moving down: both rejected.
        pulses = 0;
        btn = 4'b0011;
        tick(12);
        check("both_bad_ms", moveState, 4'd1);
        check("both_bad_pulses", pulses, 0);
        btn = 4'b0000;
        tick(8);
        steer("prio_left_right", 4'b1100, 4'd2);

        // Reset in the middle of a down debounce; down still held after release.
        btn = 4'b0010;
        tick(4);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        check("midrst_ms", moveState, 4'd3);
        check("midrst_deb", btn_deb, 0);
        check("midrst_dc", dir_changed, 1'b0);
        tick(6);
        check("midrst_e6_ms", moveState, 4'd3);
        tick(1);
        check("midrst_e7_ms", moveState, 4'd1);
        check("midrst_e7_dc", dir_changed, 1'b1);
        btn = 4'b0000;
        tick(8);

`ifdef SNAKE_DIR_PAUSE_EN
        btn_pause = 1'b1;
        tick(7);
        check("pause_ms", moveState, 4'd4);
        check("pause_dc", dir_changed, 1'b1);
        btn_pause = 1'b0;
        tick(8);
        btn_pause = 1'b1;
        tick(7);
        check("resume_ms", moveState, 4'd1);
        btn_pause = 1'b0;
        tick(8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
